// File: rtl/vc_test_pkg.sv
// Shared definitions for the val/rdy test sources and sinks: LFSR constants,
// the source state enum and the step/delay helpers used by both.
package vc_test_pkg;

  localparam int unsigned LFSR_W    = 32;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic {
    ACTIVE = 1'b0,
    DONE   = 1'b1
  } src_state_e;

  // Right-shifting Galois step: the feedback bit is the one shifted out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // 33-bit modulus so that max_delay = all-ones still gives a span of 2^32.
  function automatic logic [31:0] draw_delay(input logic [31:0] lfsr_val,
                                             input logic [31:0] max_delay);
    return 32'(({1'b0, lfsr_val} % ({1'b0, max_delay} + 33'd1)));
  endfunction

endpackage

// File: rtl/vc_test_rand_delay_source_if.sv
// Val/rdy message channel between a test source and the design under test.
interface vc_test_rand_delay_source_if #(
  parameter int unsigned p_msg_nbits = 1
);

  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input  rdy);
  modport slave  (input  val, input  msg, output rdy);

endinterface

// File: rtl/vc_test_lfsr32.sv
// 32-bit Galois LFSR that advances only when enabled; a zero seed is
// replaced by 1 so the register can never lock up.
module vc_test_lfsr32
  import vc_test_pkg::*;
#(
  parameter logic [31:0] p_seed = 32'h0000_0001
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] state,
  output logic [31:0] state_next
);

  localparam logic [31:0] SEED = (p_seed == 32'h0) ? 32'h0000_0001 : p_seed;

  logic [31:0] state_q;
  logic [31:0] state_d;

  assign state_next = lfsr_step(state_q);
  assign state_d    = en ? state_next : state_q;
  assign state      = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/vc_test_rand_delay_source.sv
// Test source: streams m[0..n_eff-1] over val/rdy, inserting a pseudo-random
// number of idle cycles (0..max_delay) after every accepted message.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   ACTIVE | sending messages or counting down the idle gap before the next
//   DONE   | every message accepted; val held low until reset
module vc_test_rand_delay_source
  import vc_test_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 1,
  parameter int unsigned p_num_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'h0000_0001
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  max_delay,
  input  logic [31:0]                  num_msgs,
  vc_test_rand_delay_source_if.master  src,
  output logic                         done
);

  localparam int unsigned IW      = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [31:0] NUM_CAP = 32'(p_num_msgs);

  // Loaded hierarchically by the bench before reset is released.
  logic [p_msg_nbits-1:0] m [p_num_msgs];

  src_state_e  fsm_q, fsm_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] count_q, count_d;
  logic [31:0] n_eff;
  logic [31:0] lfsr, lfsr_next;
  logic        lfsr_en;
  logic        val;
  logic        fire;
  logic [IW-1:0] idx_sel;

  assign n_eff = (num_msgs > NUM_CAP) ? NUM_CAP : num_msgs;

  // reset is folded in directly so val drops without waiting for a clock.
  assign val  = !reset && (fsm_q == ACTIVE) && (count_q == 32'd0) && (idx_q < n_eff);
  assign fire = val && src.rdy;
  assign done = !reset && ((fsm_q == DONE) || (idx_q >= n_eff));

  assign idx_sel  = (idx_q < NUM_CAP) ? idx_q[IW-1:0] : '0;
  assign src.val  = val;
  assign src.msg  = m[idx_sel];

  vc_test_lfsr32 #(
    .p_seed (p_seed)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .en         (lfsr_en),
    .state      (lfsr),
    .state_next (lfsr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ACTIVE;
      idx_q   <= 32'd0;
      count_q <= 32'd0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    count_d = count_q;
    lfsr_en = 1'b0;
    case (fsm_q)
      ACTIVE: begin
        if (idx_q >= n_eff) begin
          fsm_d = DONE;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else if (fire) begin
          idx_d   = idx_q + 32'd1;
          lfsr_en = 1'b1;
          count_d = draw_delay(lfsr_next, max_delay);
        end
      end
      DONE: begin
        fsm_d = DONE;
      end
    endcase
  end

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// Scoreboard bench for the random-delay source: a reference model queues
// expected (message, idle gap) pairs and a negedge monitor checks each handshake.
module tb_vc_test_rand_delay_source;

  typedef struct {
    logic [7:0] msg;
    int         gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        reset_c = 1'b1;
  logic [31:0] max_delay = 32'd0;
  logic [31:0] num_msgs = 32'd0;
  logic        rdy = 1'b1;
  logic        done_a, done_c;
  bit          sel_c = 1'b0;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_c [8];
  exp_t        exp_q [$];

  int          errors = 0;
  int          checks = 0;

  vc_test_rand_delay_source_if #(.p_msg_nbits(8)) if_a ();
  vc_test_rand_delay_source_if #(.p_msg_nbits(8)) if_c ();

  assign if_a.rdy = rdy;
  assign if_c.rdy = rdy;

  vc_test_rand_delay_source #(
    .p_msg_nbits (8),
    .p_num_msgs  (256),
    .p_seed      (32'h0000_0001)
  ) dut_a (
    .clk       (clk),
    .reset     (reset_a),
    .max_delay (max_delay),
    .num_msgs  (num_msgs),
    .src       (if_a.master),
    .done      (done_a)
  );

  // Seed 0 must behave exactly like seed 1.
  vc_test_rand_delay_source #(
    .p_msg_nbits (8),
    .p_num_msgs  (8),
    .p_seed      (32'h0000_0000)
  ) dut_c (
    .clk       (clk),
    .reset     (reset_c),
    .max_delay (max_delay),
    .num_msgs  (num_msgs),
    .src       (if_c.master),
    .done      (done_c)
  );

  logic       mv, mr, md, mrst;
  logic [7:0] mm;
  assign mv   = sel_c ? if_c.val : if_a.val;
  assign mr   = rdy;
  assign md   = sel_c ? done_c   : done_a;
  assign mm   = sel_c ? if_c.msg : if_a.msg;
  assign mrst = sel_c ? reset_c  : reset_a;

  always #5 clk = ~clk;

  function automatic void check(bit ok, string name, longint act, longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: the k-th message waits (k-th LFSR value) mod (max_delay+1) idle cycles.
  function automatic void build_expected(int n, logic [31:0] maxd, bit use_c);
    longint unsigned s = 64'd1;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        if (s % 2 == 1) s = (s / 2) ^ 64'h8020_0003;
        else            s = s / 2;
      end
      e.msg = use_c ? mem_c[k] : mem_a[k];
      e.gap = (k == 0) ? 0 : int'(s % (longint'(maxd) + 1));
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: pops on every handshake, checks message, gap and stall holding.
  int         idle = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] held = 8'h0;
  always @(negedge clk) begin
    exp_t e;
    if (mrst) begin
      idle = 0;
      stall_prev = 1'b0;
    end else if (mv) begin
      if (stall_prev) check(mm == held, "stall_msg_hold", longint'(mm), longint'(held));
      if (mr) begin
        check(!md, "done_early", longint'(md), 0);
        check(exp_q.size() != 0, "extra_msg", longint'(mm), 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(mm == e.msg, "msg", longint'(mm), longint'(e.msg));
          check(idle == e.gap, "gap", longint'(idle), longint'(e.gap));
        end
        idle = 0;
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        held = mm;
      end
    end else begin
      check(!stall_prev, "val_dropped_in_stall", 0, 1);
      stall_prev = 1'b0;
      if (!md) idle++;
    end
  end

  task automatic set_rst(logic v);
    if (sel_c) reset_c = v;
    else       reset_a = v;
  endtask

  task automatic do_reset(logic [7:0] m0);
    set_rst(1'b1);
    @(negedge clk);
    check(!mv, "rst_val", longint'(mv), 0);
    check(!md, "rst_done", longint'(md), 0);
    check(mm == m0, "rst_msg", longint'(mm), longint'(m0));
    @(posedge clk);
    #1;
    set_rst(1'b0);
  endtask

  task automatic run_stream(int budget, bit rand_rdy);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check(exp_q.size() == 0, "stream_timeout", longint'(exp_q.size()), 0);
    @(negedge clk);
    check(md, "done_after_last", longint'(md), 1);
    check(!mv, "val_after_last", longint'(mv), 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) begin
      mem_a[i]    = (i < 8) ? 8'((i + 1) * 17) : 8'($urandom);
      dut_a.m[i]  = mem_a[i];
    end
    for (int i = 0; i < 8; i++) begin
      mem_c[i]    = 8'($urandom);
      dut_c.m[i]  = mem_c[i];
    end

    // Full throughput: four back-to-back messages, done in cycle 5.
    max_delay = 32'd0;
    num_msgs  = 32'd4;
    build_expected(4, 32'd0, 1'b0);
    rdy = 1'b1;
    do_reset(mem_a[0]);
    run_stream(20, 1'b0);

    // Back-pressure: three stall cycles, accepted in cycle 4.
    build_expected(4, 32'd0, 1'b0);
    rdy = 1'b0;
    do_reset(mem_a[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(mv, "bp_val", longint'(mv), 1);
      check(mm == 8'h11, "bp_msg", longint'(mm), 64'h11);
      check(dut_a.idx_q == 32'd0, "bp_idx", longint'(dut_a.idx_q), 0);
      check(dut_a.u_lfsr.state_q == 32'd1, "bp_lfsr", longint'(dut_a.u_lfsr.state_q), 1);
      @(posedge clk);
      #1;
    end
    run_stream(20, 1'b0);

    // Random delays, rdy held high then randomized: same gap sequence.
    max_delay = 32'd3;
    num_msgs  = 32'd200;
    build_expected(200, 32'd3, 1'b0);
    do_reset(mem_a[0]);
    run_stream(2000, 1'b0);
    build_expected(200, 32'd3, 1'b0);
    rdy = 1'b1;
    do_reset(mem_a[0]);
    run_stream(4000, 1'b1);

    max_delay = 32'd7;
    num_msgs  = 32'd40;
    build_expected(40, 32'd7, 1'b0);
    rdy = 1'b1;
    do_reset(mem_a[0]);
    run_stream(2000, 1'b1);

    // Zero messages.
    num_msgs = 32'd0;
    rdy = 1'b1;
    do_reset(mem_a[0]);
    @(negedge clk);
    check(md, "zero_done", longint'(md), 1);
    for (int i = 0; i < 5; i++) begin
      check(!mv, "zero_val", longint'(mv), 0);
      @(negedge clk);
    end

    // Async reset while stalled at idx 2.
    max_delay = 32'd3;
    num_msgs  = 32'd8;
    build_expected(8, 32'd3, 1'b0);
    rdy = 1'b1;
    do_reset(mem_a[0]);
    cyc = 0;
    while (exp_q.size() > 6 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rdy = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!mv && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check(mv, "ar_val_before", longint'(mv), 1);
    check(dut_a.idx_q == 32'd2, "ar_idx_before", longint'(dut_a.idx_q), 2);
    #2;
    reset_a = 1'b1;
    #1;
    check(!mv, "ar_val_async_drop", longint'(mv), 0);
    exp_q.delete();
    build_expected(8, 32'd3, 1'b0);
    rdy = 1'b1;
    do_reset(mem_a[0]);
    @(negedge clk);
    check(dut_a.idx_q == 32'd0, "ar_idx_after", longint'(dut_a.idx_q), 0);
    run_stream(200, 1'b0);

    // Clamp: num_msgs 20 against an 8-deep array.
    reset_a  = 1'b1;
    sel_c    = 1'b1;
    num_msgs = 32'd20;
    max_delay = 32'd1;
    build_expected(8, 32'd1, 1'b1);
    rdy = 1'b1;
    do_reset(mem_c[0]);
    run_stream(200, 1'b1);
    check(dut_c.idx_q == 32'd8, "clamp_idx", longint'(dut_c.idx_q), 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(!mv && md, "clamp_idle", longint'({mv, md}), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
